// File: rtl/kulisch_acc_ctrl_pkg.sv
// Shared definitions for the Kulisch accumulator controller.
// Holds the FSM state encoding, default parameter values and a
// sign-extension helper used by the accumulate stage.
package kulisch_acc_pkg;

  localparam int NUM_DEF    = 4;
  localparam int DWIDTH_DEF = 16;
  localparam int AWIDTH_DEF = 91;   // W=79 + V=12
  localparam int LWIDTH_DEF = 8;

  // Widest value the sign-extend helper handles; AWIDTH must not exceed it.
  localparam int SEXT_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Sign-extends the low w bits of v to SEXT_W bits. Callers truncate the
  // result to their own width.
  function automatic logic [SEXT_W-1:0] sext(input logic [SEXT_W-1:0] v,
                                             input int unsigned w);
    logic [SEXT_W-1:0] shl;
    shl = v << (SEXT_W - w);
    return $signed(shl) >>> (SEXT_W - w);
  endfunction

endpackage

// File: rtl/kulisch_acc_ctrl_if.sv
// Bus bundle for kulisch_acc_ctrl: job control, operand beat handshake,
// adder-tree connection and result handshake.
//   slave  : the controller (drives o_* signals)
//   master : the surrounding logic (drives i_* signals)
interface kulisch_acc_ctrl_if
  import kulisch_acc_pkg::*;
#(
  parameter int NUM    = NUM_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int LWIDTH = LWIDTH_DEF
);
  logic                       i_start;
  logic [LWIDTH-1:0]          i_len;
  logic                       o_busy;
  logic                       i_valid;
  logic                       o_ready;
  logic [NUM*DWIDTH-1:0]      i_sum_mul;
  logic [NUM*DWIDTH-1:0]      i_carry_mul;
  logic [2*NUM*DWIDTH-1:0]    o_tree_in;
  logic [DWIDTH-1:0]          i_tree_out0;
  logic [DWIDTH-1:0]          i_tree_out1;
  logic                       o_res_valid;
  logic                       i_res_ready;
  logic [AWIDTH-1:0]          o_res;
  logic                       o_ovf;

  modport slave (
    input  i_start, i_len, i_valid, i_sum_mul, i_carry_mul,
           i_tree_out0, i_tree_out1, i_res_ready,
    output o_busy, o_ready, o_tree_in, o_res_valid, o_res, o_ovf
  );

  modport master (
    output i_start, i_len, i_valid, i_sum_mul, i_carry_mul,
           i_tree_out0, i_tree_out1, i_res_ready,
    input  o_busy, o_ready, o_tree_in, o_res_valid, o_res, o_ovf
  );
endinterface

// File: rtl/kulisch_acc_ctrl_pipe.sv
// Two-stage accumulate pipeline behind the adder tree.
//   clear     : start of a new job; zeroes accumulator and overflow flag
//   beat      : an operand beat is accepted this cycle
//   tree_out* : combinational adder-tree outputs for the current beat
//   acc/ovf   : running wrapped sum and sticky signed-overflow flag
//   empty     : no beat is still in flight towards the accumulator
module kulisch_acc_pipe
  import kulisch_acc_pkg::*;
#(
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              beat,
  input  logic [DWIDTH-1:0] tree_out0,
  input  logic [DWIDTH-1:0] tree_out1,
  output logic [AWIDTH-1:0] acc,
  output logic              ovf,
  output logic              empty
);

  logic              s1_valid;
  logic [DWIDTH-1:0] s1_out0;
  logic [DWIDTH-1:0] s1_out1;

  logic [AWIDTH-1:0]        add0;
  logic [AWIDTH-1:0]        add1;
  logic signed [AWIDTH+1:0] exact;
  logic [AWIDTH-1:0]        acc_next;
  logic                     step_ovf;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= beat;
    end
  end

  // NOTE: pure datapath registers carry no reset; s1_valid qualifies them.
  always_ff @(posedge clk) begin
    if (beat) begin
      s1_out0 <= tree_out0;
      s1_out1 <= tree_out1;
    end
  end

  // Three AWIDTH-bit signed terms fit exactly in AWIDTH+2 bits, so the step
  // overflowed whenever the two guard bits disagree with the result sign.
  // NOTE: every combinational output is assigned on all paths, so no latch.
  always_comb begin
    add0     = AWIDTH'(sext(SEXT_W'(s1_out0), DWIDTH));
    add1     = AWIDTH'(sext(SEXT_W'(s1_out1), DWIDTH));
    exact    = $signed({{2{acc[AWIDTH-1]}},  acc})
             + $signed({{2{add0[AWIDTH-1]}}, add0})
             + $signed({{2{add1[AWIDTH-1]}}, add1});
    acc_next = exact[AWIDTH-1:0];
    step_ovf = (exact[AWIDTH+1:AWIDTH] != {2{exact[AWIDTH-1]}});
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      acc <= '0;
      ovf <= 1'b0;
    end else if (s1_valid) begin
      acc <= acc_next;
      ovf <= ovf | step_ovf;
    end
  end

  // The accumulate stage retires on the same edge s1_valid drops, so a clear
  // stage 1 means the accumulator already holds every accepted beat.
  assign empty = !s1_valid;

endmodule

// File: rtl/kulisch_acc_ctrl.sv
// Kulisch dot-product job sequencer. Accepts a start with a beat count,
// streams operand beats into the carry-save adder tree, accumulates the
// two tree outputs into a wide fixed-point accumulator and hands the sum
// back over a valid/ready result port.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : kulisch_acc_ctrl_if slave (start/len, beat handshake,
//                tree in/out, result handshake, overflow flag)
module kulisch_acc_ctrl
  import kulisch_acc_pkg::*;
#(
  parameter int NUM    = NUM_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int LWIDTH = LWIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  kulisch_acc_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE  = ST_IDLE;
  localparam logic [1:0] ACCUM = ST_ACCUM;
  localparam logic [1:0] DRAIN = ST_DRAIN;
  localparam logic [1:0] DONE  = ST_DONE;

  logic [1:0]        state;
  logic [LWIDTH-1:0] cnt;
  logic [LWIDTH-1:0] len;
  logic              start_ok;
  logic              beat;
  logic              pipe_empty;
  logic [AWIDTH-1:0] acc;
  logic              ovf;

  // Tree input lane i is {sum[i], carry[i]}; the tree itself is external.
  for (genvar i = 0; i < NUM; i++) begin : g_lane
    assign bus.o_tree_in[i*2*DWIDTH +: 2*DWIDTH] =
      {bus.i_sum_mul[i*DWIDTH +: DWIDTH], bus.i_carry_mul[i*DWIDTH +: DWIDTH]};
  end

  assign start_ok        = (state == IDLE) && bus.i_start;
  assign bus.o_ready     = (state == ACCUM) && (cnt < len);
  assign beat            = bus.i_valid && bus.o_ready;
  assign bus.o_busy      = (state != IDLE);
  assign bus.o_res_valid = (state == DONE);
  assign bus.o_res       = acc;
  assign bus.o_ovf       = ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      len   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.i_start) begin
            len   <= bus.i_len;
            cnt   <= '0;
            state <= (bus.i_len == '0) ? DONE : ACCUM;
          end
        end
        ACCUM: begin
          if (beat) begin
            cnt <= cnt + 1'b1;
            if (cnt == len - 1'b1) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pipe_empty) state <= DONE;
        end
        DONE: begin
          if (bus.i_res_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  kulisch_acc_pipe #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (start_ok),
    .beat      (beat),
    .tree_out0 (bus.i_tree_out0),
    .tree_out1 (bus.i_tree_out1),
    .acc       (acc),
    .ovf       (ovf),
    .empty     (pipe_empty)
  );

endmodule
